// File: rtl/ms_sched_pkg.sv
// Shared definitions for the millisecond delay scheduler.
// Contents:
//   CH_IDLE / CH_RUN   - per-channel state encoding
//   DEF_CYCLES_PER_MS  - default clk cycles per ms tick (50 MHz clock)
//   DEF_DLY_W          - default delay width in ms
//   tick_cnt_width()   - bits needed for a counter that reaches max_count
package ms_sched_pkg;

    localparam logic CH_IDLE = 1'b0;
    localparam logic CH_RUN  = 1'b1;

    localparam int unsigned DEF_CYCLES_PER_MS = 50000;
    localparam int unsigned DEF_DLY_W         = 16;

    // The tick counter counts 1..max_count inclusive, so it needs clog2(max_count+1) bits.
    function automatic int unsigned tick_cnt_width(input int unsigned max_count);
        return (max_count > 1) ? $clog2(max_count + 1) : 1;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Shared 1 ms time base. While enabled, the counter runs 1..CYCLES_PER_MS and
// emits a one-cycle registered tick on wrap; while disabled it is parked at 1.
// Ports:
//   clk    - system clock
//   rst    - synchronous, active-low reset
//   enable - run the time base (at least one channel counting)
//   tick   - one-cycle registered ms tick
module ms_tick_gen
    import ms_sched_pkg::*;
#(
    parameter int unsigned CYCLES_PER_MS = DEF_CYCLES_PER_MS
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int unsigned     CntW   = tick_cnt_width(CYCLES_PER_MS);
    localparam logic [CntW-1:0] CntMax = CntW'(CYCLES_PER_MS);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [CntW-1:0] count_q, count_d;
    logic            tick_d;

    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (!enable) begin
            count_d = CntOne;
        end else if (count_q == CntMax) begin
            count_d = CntOne;
            tick_d  = 1'b1;
        end else begin
            count_d = count_q + CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= CntOne;
            tick    <= 1'b0;
        end else begin
            count_q <= count_d;
            tick    <= tick_d;
        end
    end

endmodule

// File: rtl/ms_delay_scheduler.sv
// Multi-channel millisecond delay scheduler. Requesters load a delay through a
// round-robin req/ack handshake; each channel counts down on the shared ms tick
// and pulses done on expiry. The time base only runs while a channel is busy.
// Optional build macro AUTO_RELOAD_EN: channels granted with periodic=1 reload
// their delay on expiry and keep running until cancelled. Without the macro the
// periodic port is ignored and every channel is one-shot.
// Ports:
//   clk      - system clock
//   rst      - synchronous, active-low reset
//   req      - per-channel load request, held until ack
//   delay_ms - per-channel delay in ms, channel i at [i*DLY_W +: DLY_W]
//   cancel   - per-channel abort of a running delay
//   periodic - per-channel auto-reload select (AUTO_RELOAD_EN builds only)
//   ack      - one-cycle grant pulse
//   busy     - channel is counting
//   done     - one-cycle expiry pulse
//   tick_ms  - one-cycle shared ms tick
module ms_delay_scheduler
    import ms_sched_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CYCLES_PER_MS = DEF_CYCLES_PER_MS,
    parameter int unsigned DLY_W         = DEF_DLY_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH*DLY_W-1:0] delay_ms,
    input  logic [NUM_CH-1:0]       cancel,
    input  logic [NUM_CH-1:0]       periodic,
    output logic [NUM_CH-1:0]       ack,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic                    tick_ms
);

    localparam int unsigned     PtrW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PtrW-1:0] PtrLast = PtrW'(NUM_CH - 1);

    logic [NUM_CH-1:0] run;
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] gnt;
    logic              grant_valid;
    logic [PtrW-1:0]   grant_idx;
    logic [PtrW-1:0]   cand;
    logic [PtrW-1:0]   ptr_q, ptr_d;

`ifndef AUTO_RELOAD_EN
    logic unused_periodic;
    assign unused_periodic = ^periodic;
`endif

    // ---------------------------------------------------------------------
    // Shared time base
    // ---------------------------------------------------------------------
    ms_tick_gen #(
        .CYCLES_PER_MS (CYCLES_PER_MS)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (|run),
        .tick   (tick_ms)
    );

    // ---------------------------------------------------------------------
    // Round-robin arbiter: a running channel is never eligible, so its
    // request simply stays pending until the channel returns to idle.
    // ---------------------------------------------------------------------
    assign elig = req & ~run;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = PtrW'((32'(ptr_q) + i) % NUM_CH);
            if (!grant_valid && elig[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        if (grant_valid) begin
            gnt   = NUM_CH'(1) << grant_idx;
            ptr_d = (grant_idx == PtrLast) ? '0 : grant_idx + PtrW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
            ack   <= '0;
        end else begin
            ptr_q <= ptr_d;
            ack   <= gnt;
        end
    end

    // ---------------------------------------------------------------------
    // Channel array
    // ---------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             state_q, state_d;
        logic [DLY_W-1:0] rem_q, rem_d;
        logic [DLY_W-1:0] dly;
        logic             expire;
        logic             done_q, done_d;
`ifdef AUTO_RELOAD_EN
        logic [DLY_W-1:0] rel_q, rel_d;
        logic             per_q, per_d;
`endif

        assign dly = delay_ms[g*DLY_W +: DLY_W];

        // Cancel wins over a coincident expiring tick.
        assign expire = (state_q == CH_RUN) && !cancel[g] && tick_ms &&
                        (rem_q == DLY_W'(1));

        // Next-state
        always_comb begin
            state_d = state_q;
            rem_d   = rem_q;
`ifdef AUTO_RELOAD_EN
            rel_d   = rel_q;
            per_d   = per_q;
`endif
            if (state_q == CH_RUN) begin
                if (cancel[g]) begin
                    state_d = CH_IDLE;
                end else if (tick_ms) begin
                    if (rem_q > DLY_W'(1)) begin
                        rem_d = rem_q - DLY_W'(1);
                    end else begin
`ifdef AUTO_RELOAD_EN
                        if (per_q) begin
                            rem_d = rel_q;
                        end else begin
                            state_d = CH_IDLE;
                        end
`else
                        state_d = CH_IDLE;
`endif
                    end
                end
            end else if (gnt[g]) begin
                rem_d = dly;
`ifdef AUTO_RELOAD_EN
                rel_d = dly;
                per_d = periodic[g];
`endif
                // A zero delay completes at grant and never enters RUN.
                if (dly != '0) begin
                    state_d = CH_RUN;
                end
            end
        end

        // Outputs (registered below)
        always_comb begin
            done_d = expire || ((state_q == CH_IDLE) && gnt[g] && (dly == '0));
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                state_q <= CH_IDLE;
                rem_q   <= '0;
                done_q  <= 1'b0;
`ifdef AUTO_RELOAD_EN
                rel_q   <= '0;
                per_q   <= 1'b0;
`endif
            end else begin
                state_q <= state_d;
                rem_q   <= rem_d;
                done_q  <= done_d;
`ifdef AUTO_RELOAD_EN
                rel_q   <= rel_d;
                per_q   <= per_d;
`endif
            end
        end

        assign run[g]  = (state_q == CH_RUN);
        assign busy[g] = run[g];
        assign done[g] = done_q;
    end

endmodule

// File: tb/tb_ms_delay_scheduler.sv
// Self-checking bench for ms_delay_scheduler with a 10-cycle ms tick.
// Cycle n is the interval after the n-th rising edge of a scenario; outputs are
// sampled and inputs changed on the falling edge inside that interval.
module tb_ms_delay_scheduler;

    localparam int NUM_CH = 4;
    localparam int CPM    = 10;
    localparam int DLY_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       req;
    logic [NUM_CH*DLY_W-1:0] delay_ms;
    logic [NUM_CH-1:0]       cancel;
    logic [NUM_CH-1:0]       periodic;
    logic [NUM_CH-1:0]       ack;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done;
    logic                    tick_ms;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    ms_delay_scheduler #(
        .NUM_CH        (NUM_CH),
        .CYCLES_PER_MS (CPM),
        .DLY_W         (DLY_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .delay_ms (delay_ms),
        .cancel   (cancel),
        .periodic (periodic),
        .ack      (ack),
        .busy     (busy),
        .done     (done),
        .tick_ms  (tick_ms)
    );

    // Leaves the bench on a falling edge, reset released: that is cycle 0.
    task automatic do_reset();
        rst      = 1'b0;
        req      = '0;
        cancel   = '0;
        periodic = '0;
        delay_ms = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        req      = 4'hF;
        cancel   = '0;
        periodic = '0;
        delay_ms = {4{16'd5}};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({ack, busy, done, tick_ms} !== 13'h0) begin
                errors++;
                $display("FAIL reset cyc%0d: ack=%b busy=%b done=%b tick=%b, want all 0",
                         i, ack, busy, done, tick_ms);
            end
        end
    endtask

    task automatic test_single_shot();
        logic exp_tick, exp_done, exp_busy;
        do_reset();
        delay_ms[15:0] = 16'd3;
        req = 4'b0001;
        @(negedge clk);
        vectors++;
        if (ack !== 4'b0001 || busy !== 4'b0001) begin
            errors++;
            $display("FAIL single_ack: ack=%b busy=%b, want ack=0001 busy=0001", ack, busy);
        end
        req = '0;
        for (int n = 2; n <= 45; n++) begin
            @(negedge clk);
            exp_tick = (n > 1) && ((n - 1) % CPM == 0) && (n <= 1 + 3 * CPM);
            exp_done = (n == 1 + 3 * CPM + 1);
            exp_busy = (n < 1 + 3 * CPM + 1);
            vectors++;
            if ({busy[0], done[0], tick_ms} !== {exp_busy, exp_done, exp_tick}) begin
                errors++;
                $display("FAIL single n=%0d: busy=%b done=%b tick=%b, want %b %b %b",
                         n, busy[0], done[0], tick_ms, exp_busy, exp_done, exp_tick);
            end
        end
    endtask

    task automatic test_round_robin();
        int seen;
        logic [3:0] seen_done;
        do_reset();
        delay_ms = {4{16'd5}};
        req = 4'hF;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            vectors++;
            if (ack !== 4'(1 << (n - 1))) begin
                errors++;
                $display("FAIL rr_ack n=%0d: ack=%b, want %b", n, ack, 4'(1 << (n - 1)));
            end
            req[n-1] = 1'b0;
        end
        // All four share the first tick, so they expire together.
        seen = -1;
        seen_done = '0;
        for (int n = 5; n <= 100; n++) begin
            @(negedge clk);
            if (done !== 4'h0) begin
                seen = n;
                seen_done = done;
                break;
            end
        end
        vectors++;
        if (seen != 52 || seen_done !== 4'hF) begin
            errors++;
            $display("FAIL rr_done: cycle=%0d done=%b, want cycle=52 done=1111", seen, seen_done);
        end
        req = 4'b0101;
        @(negedge clk);
        vectors++;
        if (ack !== 4'b0001) begin
            errors++;
            $display("FAIL rr_wrap_first: ack=%b, want 0001", ack);
        end
        req[0] = 1'b0;
        @(negedge clk);
        vectors++;
        if (ack !== 4'b0100) begin
            errors++;
            $display("FAIL rr_wrap_second: ack=%b, want 0100", ack);
        end
        req = '0;
    endtask

    task automatic test_zero_delay();
        do_reset();
        delay_ms[31:16] = 16'd0;
        req = 4'b0010;
        @(negedge clk);
        vectors++;
        if (ack !== 4'b0010 || done !== 4'b0010 || busy !== 4'b0000) begin
            errors++;
            $display("FAIL zero_grant: ack=%b done=%b busy=%b, want 0010 0010 0000",
                     ack, done, busy);
        end
        req = '0;
        for (int n = 2; n <= 15; n++) begin
            @(negedge clk);
            vectors++;
            if ({ack, busy, done, tick_ms} !== 13'h0) begin
                errors++;
                $display("FAIL zero_after n=%0d: ack=%b busy=%b done=%b tick=%b, want all 0",
                         n, ack, busy, done, tick_ms);
            end
        end
    endtask

    task automatic test_cancel();
        do_reset();
        delay_ms[63:48] = 16'd4;
        req = 4'b1000;
        @(negedge clk);
        req = '0;
        for (int n = 2; n <= 25; n++) @(negedge clk);
        cancel = 4'b1000;
        @(negedge clk);
        vectors++;
        if (busy !== 4'b0000 || done !== 4'b0000) begin
            errors++;
            $display("FAIL cancel_drop: busy=%b done=%b, want 0000 0000", busy, done);
        end
        cancel = '0;
        for (int n = 27; n <= 60; n++) begin
            @(negedge clk);
            vectors++;
            if (done !== 4'b0000 || tick_ms !== 1'b0) begin
                errors++;
                $display("FAIL cancel_quiet n=%0d: done=%b tick=%b, want 0000 0", n, done, tick_ms);
            end
        end

        // Cancel coinciding with the expiring tick.
        do_reset();
        delay_ms[63:48] = 16'd2;
        req = 4'b1000;
        @(negedge clk);
        req = '0;
        for (int n = 2; n <= 21; n++) @(negedge clk);
        vectors++;
        if (tick_ms !== 1'b1) begin
            errors++;
            $display("FAIL cancel_tick_seen: tick=%b, want 1", tick_ms);
        end
        cancel = 4'b1000;
        @(negedge clk);
        vectors++;
        if (done !== 4'b0000 || busy !== 4'b0000) begin
            errors++;
            $display("FAIL cancel_coincident: done=%b busy=%b, want 0000 0000", done, busy);
        end
        cancel = '0;
    endtask

    task automatic test_periodic();
        logic exp_done, exp_busy;
        do_reset();
        delay_ms[47:32] = 16'd2;
        periodic = 4'b0100;
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        periodic = '0;
`ifdef AUTO_RELOAD_EN
        for (int n = 2; n <= 102; n++) begin
            @(negedge clk);
            exp_done = (n >= 22) && ((n - 22) % (2 * CPM) == 0);
            exp_busy = 1'b1;
            vectors++;
            if ({busy[2], done[2]} !== {exp_busy, exp_done}) begin
                errors++;
                $display("FAIL periodic n=%0d: busy=%b done=%b, want %b %b",
                         n, busy[2], done[2], exp_busy, exp_done);
            end
        end
        cancel = 4'b0100;
        @(negedge clk);
        cancel = '0;
        for (int n = 103; n <= 140; n++) begin
            @(negedge clk);
            vectors++;
            if (busy[2] !== 1'b0 || done[2] !== 1'b0) begin
                errors++;
                $display("FAIL periodic_cancel n=%0d: busy=%b done=%b, want 0 0",
                         n, busy[2], done[2]);
            end
        end
`else
        // Without auto-reload the periodic bit has no effect.
        for (int n = 2; n <= 60; n++) begin
            @(negedge clk);
            exp_done = (n == 22);
            exp_busy = (n < 22);
            vectors++;
            if ({busy[2], done[2]} !== {exp_busy, exp_done}) begin
                errors++;
                $display("FAIL oneshot_periodic n=%0d: busy=%b done=%b, want %b %b",
                         n, busy[2], done[2], exp_busy, exp_done);
            end
        end
`endif
    endtask

    // Each trial starts with the time base idle: grants follow round-robin order
    // on consecutive cycles, the base starts at the first non-zero grant s, ticks
    // appear every CPM cycles after s while a channel was busy the cycle before,
    // and a channel granted at a with delay D expires one cycle after its D-th
    // tick at or after a.
    task automatic test_random();
        int         ptr;
        logic [3:0] mask;
        int         dly[4];
        int         ack_at[4];
        int         done_at[4];
        int         busy_end[4];
        int         k, last_c, s, last_busy, horizon, m, t1;
        int         cancel_ch, cancel_at, start;
        logic [3:0] e_ack, e_done, e_busy;
        logic       e_tick;

        do_reset();
        ptr = 0;
        for (int t = 0; t < 20; t++) begin
            mask = 4'($urandom_range(1, 15));
            for (int c = 0; c < 4; c++) begin
                dly[c]      = $urandom_range(0, 4);
                ack_at[c]   = -1;
                done_at[c]  = -1;
                busy_end[c] = -1;
            end
            k = 0;
            last_c = 0;
            for (int j = 0; j < 4; j++) begin
                if (mask[(ptr + j) % 4]) begin
                    k++;
                    ack_at[(ptr + j) % 4] = k;
                    last_c = (ptr + j) % 4;
                end
            end
            ptr = (last_c + 1) % 4;
            s = -1;
            for (int c = 0; c < 4; c++)
                if (mask[c] && dly[c] != 0 && (s < 0 || ack_at[c] < s)) s = ack_at[c];
            for (int c = 0; c < 4; c++) begin
                if (!mask[c]) continue;
                if (dly[c] == 0) begin
                    done_at[c]  = ack_at[c];
                    busy_end[c] = ack_at[c];
                end else begin
                    m = (ack_at[c] - s + CPM - 1) / CPM;
                    if (m < 1) m = 1;
                    t1 = s + m * CPM;
                    done_at[c]  = t1 + (dly[c] - 1) * CPM + 1;
                    busy_end[c] = done_at[c];
                end
            end
            cancel_ch = -1;
            cancel_at = -1;
            if ($urandom_range(0, 1) == 1) begin
                start = $urandom_range(0, 3);
                for (int j = 0; j < 4; j++) begin
                    if (cancel_ch < 0 && mask[(start + j) % 4] && dly[(start + j) % 4] != 0)
                        cancel_ch = (start + j) % 4;
                end
                if (cancel_ch >= 0) begin
                    cancel_at = $urandom_range(k + 1, done_at[cancel_ch] - 1);
                    busy_end[cancel_ch] = cancel_at + 1;
                    done_at[cancel_ch]  = -1;
                end
            end
            last_busy = -1;
            horizon = k;
            for (int c = 0; c < 4; c++) begin
                if (mask[c] && dly[c] != 0 && busy_end[c] - 1 > last_busy)
                    last_busy = busy_end[c] - 1;
                if (busy_end[c] > horizon) horizon = busy_end[c];
            end
            horizon = horizon + 3;

            req = mask;
            for (int c = 0; c < 4; c++) delay_ms[c*DLY_W +: DLY_W] = 16'(dly[c]);
`ifdef AUTO_RELOAD_EN
            periodic = '0;
`else
            periodic = 4'($urandom_range(0, 15));
`endif
            for (int n = 1; n <= horizon; n++) begin
                @(negedge clk);
                for (int c = 0; c < 4; c++) begin
                    e_ack[c]  = (ack_at[c] == n);
                    e_done[c] = (done_at[c] == n);
                    e_busy[c] = mask[c] && dly[c] != 0 && ack_at[c] <= n && n < busy_end[c];
                end
                e_tick = (s > 0) && (n > s) && ((n - s) % CPM == 0) && (n - 1 <= last_busy);
                vectors++;
                if ({ack, done, busy, tick_ms} !== {e_ack, e_done, e_busy, e_tick}) begin
                    errors++;
                    $display("FAIL random t=%0d n=%0d: ack=%b done=%b busy=%b tick=%b, want %b %b %b %b",
                             t, n, ack, done, busy, tick_ms, e_ack, e_done, e_busy, e_tick);
                end
                for (int c = 0; c < 4; c++) if (ack_at[c] == n) req[c] = 1'b0;
                cancel = '0;
                if (cancel_ch >= 0 && n == cancel_at) cancel[cancel_ch] = 1'b1;
            end
            cancel = '0;
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_round_robin();
        test_zero_delay();
        test_cancel();
        test_periodic();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ms_delay_scheduler.md
Name: ms_delay_scheduler

Overview:
- Multi-channel millisecond delay scheduler for the sudoku datapath, for uses such as debounce, blink, game clock and display holds.
- Owns one shared 1 ms time base. Requesters load delays of D ms through a round-robin req/ack handshake.
- Each channel counts down on shared ms ticks and pulses done on expiry.
- The time base runs only while at least one channel is busy.

Parameters:
- NUM_CH, 4: number of requester channels.
- CYCLES_PER_MS, 50000: clk cycles per ms tick (50 MHz).
- DLY_W, 16: width of each delay value, in ms.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- req  in  NUM_CH  per-channel load request; level, held until ack
- delay_ms  in  NUM_CH*DLY_W  per-channel delay; channel i at bits [i*DLY_W +: DLY_W]
- cancel  in  NUM_CH  per-channel abort
- periodic  in  NUM_CH  per-channel auto-reload select (see Optional Feature)
- ack  out  NUM_CH  one-cycle grant pulse
- busy  out  NUM_CH  channel is counting
- done  out  NUM_CH  one-cycle expiry pulse
- tick_ms  out  1  one-cycle shared ms tick

Behaviour:
- Reset (rst==0 at a clk edge): ack, busy, done, tick_ms = 0; all channels IDLE; tick counter = 1; round-robin pointer = 0. Reset mid-count discards all pending delays with no done.
- Tick generator:
  - Enabled when any channel is in RUN (registered state).
  - Disabled: count <= 1, tick_ms <= 0.
  - Enabled: count < CYCLES_PER_MS increments it with tick_ms <= 0; count == CYCLES_PER_MS gives tick_ms <= 1 and count <= 1.
- Channel FSM, per channel: IDLE -> RUN -> IDLE.
  - A RUN channel holds remaining[DLY_W] and reload[DLY_W].
- Arbiter:
  - Eligible channels: req=1 and state IDLE.
  - At most one grant per cycle, searching from the pointer upward with wrap.
  - On grant of channel g: pointer <= g+1 mod NUM_CH; ack[g] registered high for one cycle.
  - Same grant edge: remaining <= delay_ms[g]; reload <= delay_ms[g].
  - delay_ms != 0: enter RUN and busy[g] <= 1.
  - delay_ms == 0: stay IDLE and assert done[g] in the same cycle as ack[g].
- req on a RUN channel is not eligible: no ack, request stays pending.
- Countdown in RUN, on each cycle with tick_ms=1:
  - remaining > 1: decrement.
  - remaining == 1: done <= 1 for one cycle, state <= IDLE, busy <= 0.
- Latency: with the time base idle at grant, done asserts exactly D*CYCLES_PER_MS+1 cycles after ack. With the time base already running, expiry falls within (D-1, D] ms after ack.
- cancel:
  - Channel in RUN: state <= IDLE, busy <= 0, no done. Cancel beats a coincident expiring tick.
  - Channel in IDLE: cancel is ignored, and a same-cycle req is still eligible.
- All channels share a single tick, so simultaneous expiries pulse done on several channels in the same cycle.
- All outputs are registered.

Optional Feature:
- Macro AUTO_RELOAD_EN.
- Defined: a channel whose periodic bit was 1 at grant captures that bit. On expiry it pulses done, reloads remaining <= reload and stays RUN (busy stays 1). It repeats until cancel.
- Not defined: the periodic port is present but ignored; every channel is one-shot.

Decomposition:
- Shared package ms_sched_pkg:
  - channel state localparams CH_IDLE=1'b0, CH_RUN=1'b1
  - default CYCLES_PER_MS, DLY_W constants
  - tick counter width function (clog2)
- One sub-module, ms_tick_gen (enable, tick). The arbiter and channel array stay in the top module, implemented with a generate loop.

Test Plan (CYCLES_PER_MS=10, NUM_CH=4, DLY_W=16):
1. Reset: hold rst=0 for 3 cycles with req=4'hF -> ack, busy, done, tick_ms all 0; no grant while in reset.
2. Single shot: ch0 req, delay 3, time base idle -> ack[0] next cycle, busy[0]=1, tick_ms every 10 cycles, done[0] exactly 31 cycles after ack[0], then busy[0]=0 and tick_ms stops.
3. Round robin: req=4'hF at once with delays 5,5,5,5 -> ack order 0,1,2,3 on consecutive cycles. Then ch0 and ch2 re-request after expiry -> ch0 granted first, since the pointer wrapped to 0.
4. Zero delay: ch1 req, delay 0 -> ack[1] and done[1] in the same cycle; busy[1] never rises.
5. Cancel: ch3 delay 4, cancel[3] after 25 cycles -> busy[3] drops next cycle, no done[3], tick_ms stays 0 afterwards. Also assert cancel on the expiring tick cycle -> no done.
6. With AUTO_RELOAD_EN: ch2 periodic=1, delay 2 -> done[2] every 20 cycles for 5 periods with busy[2] held at 1. After cancel[2], no further done[2].
